// File: rtl/gba_bus_arbiter_pkg.sv
// Shared definitions for the GBA system bus: ownership states, access sizes, DMA count.
package gba_core_defines;

  typedef enum logic [1:0] {
    CPU_OWN   = 2'd0,
    HANDOFF_D = 2'd1,
    DMA_OWN   = 2'd2,
    HANDOFF_C = 2'd3
  } bus_owner_t;

  localparam logic [1:0] BUS_SIZE_BYTE = 2'd0;
  localparam logic [1:0] BUS_SIZE_HALF = 2'd1;
  localparam logic [1:0] BUS_SIZE_WORD = 2'd2;

  localparam int unsigned GBA_NUM_DMA = 4;

endpackage

// File: rtl/gba_bus_arbiter_prio_encoder.sv
// Lowest-index-wins priority encoder with a "something outranks the owner" test.
module gba_prio_encoder #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] owner,
  output logic          valid,
  output logic [IW-1:0] index,
  output logic          higher
);

  always_comb begin
    valid  = |req;
    index  = '0;
    higher = 1'b0;
    // Scan downwards so the lowest requesting index is the last one written.
    for (int unsigned i = N; i > 0; i--) begin
      if (req[IW'(i - 1)]) index = IW'(i - 1);
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (req[IW'(i)] && (IW'(i) < owner)) higher = 1'b1;
    end
  end

endmodule

// File: rtl/gba_bus_arbiter.sv
// System bus arbiter: CPU vs. fixed-priority DMA channels, with one-cycle handoffs.
module gba_bus_arbiter
  import gba_core_defines::*;
#(
  parameter int unsigned NUM_DMA = GBA_NUM_DMA,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               cpu_addr,
  input  logic [31:0]               cpu_wdata,
  input  logic [1:0]                cpu_size,
  input  logic                      cpu_write,
  input  logic                      cpu_preemptable,
  output logic                      cpu_pause,
  input  logic [NUM_DMA-1:0]        dma_req,
  input  logic [NUM_DMA-1:0]        dma_boundary,
  input  logic [NUM_DMA-1:0][31:0]  dma_addr,
  input  logic [NUM_DMA-1:0][31:0]  dma_wdata,
  input  logic [NUM_DMA-1:0][1:0]   dma_size,
  input  logic [NUM_DMA-1:0]        dma_write,
  output logic [NUM_DMA-1:0]        dma_gnt,
  output logic                      dma_active,
  output logic [31:0]               bus_addr,
  output logic [31:0]               bus_wdata,
  output logic [1:0]                bus_size,
  output logic                      bus_write,
  input  logic                      bus_pause,
  output logic [CNT_W-1:0]          owner_cycles
);

  localparam int unsigned IW = (NUM_DMA > 1) ? $clog2(NUM_DMA) : 1;

  bus_owner_t    state, state_nxt;
  logic [IW-1:0] owner, owner_nxt;
  logic [IW-1:0] win;
  logic          win_valid, higher, safe, cpu_hold;

  gba_prio_encoder #(.N(NUM_DMA), .IW(IW)) u_prio (
    .req    (dma_req),
    .owner  (owner),
    .valid  (win_valid),
    .index  (win),
    .higher (higher)
  );

  assign safe      = ~bus_pause;
  assign cpu_pause = bus_pause | cpu_hold;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= CPU_OWN;
      owner        <= '0;
      owner_cycles <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (state_nxt != state)
        owner_cycles <= '0;
      else if (owner_cycles != '1)
        owner_cycles <= owner_cycles + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    cpu_hold   = 1'b1;
    dma_gnt    = '0;
    dma_active = 1'b0;
    bus_addr   = cpu_addr;
    bus_wdata  = cpu_wdata;
    bus_size   = cpu_size;
    bus_write  = cpu_write;

    case (state)
      CPU_OWN: begin
        cpu_hold = 1'b0;
        if (win_valid && cpu_preemptable && safe) begin
          state_nxt = HANDOFF_D;
          owner_nxt = win;
        end
      end
      HANDOFF_D: begin
        bus_addr  = dma_addr[owner];
        bus_wdata = dma_wdata[owner];
        bus_size  = dma_size[owner];
        bus_write = 1'b0;
        state_nxt = DMA_OWN;
      end
      DMA_OWN: begin
        dma_gnt[owner] = 1'b1;
        dma_active     = 1'b1;
        bus_addr       = dma_addr[owner];
        bus_wdata      = dma_wdata[owner];
        bus_size       = dma_size[owner];
        bus_write      = dma_write[owner];
        // Owner dropping takes precedence; with req[owner] low, win_valid means another channel.
        if (!dma_req[owner] && safe) begin
          if (win_valid) begin
            state_nxt = HANDOFF_D;
            owner_nxt = win;
          end else begin
            state_nxt = HANDOFF_C;
          end
        end else if (higher && dma_boundary[owner] && safe) begin
          state_nxt = HANDOFF_D;
          owner_nxt = win;
        end
      end
      HANDOFF_C: begin
        bus_write = 1'b0;
        state_nxt = CPU_OWN;
      end
      default: state_nxt = CPU_OWN;
    endcase
  end

endmodule

// File: tb/tb_gba_bus_arbiter.sv
// Self-checking bench for gba_bus_arbiter: vector table, directed corner sequences, random vs. model.
module tb_gba_bus_arbiter;

  localparam int NONE = -2;
  localparam int CPU  = -1;

  logic              clock = 1'b0;
  logic              reset;
  logic [31:0]       cpu_addr, cpu_wdata;
  logic [1:0]        cpu_size;
  logic              cpu_write, cpu_preemptable, cpu_pause;
  logic [3:0]        dma_req, dma_boundary, dma_write, dma_gnt;
  logic [3:0][31:0]  dma_addr, dma_wdata;
  logic [3:0][1:0]   dma_size;
  logic              dma_active;
  logic [31:0]       bus_addr, bus_wdata;
  logic [1:0]        bus_size;
  logic              bus_write, bus_pause;
  logic [15:0]       owner_cycles;

  int errors = 0;
  int checks = 0;

  gba_bus_arbiter #(.NUM_DMA(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_size(cpu_size),
    .cpu_write(cpu_write), .cpu_preemptable(cpu_preemptable), .cpu_pause(cpu_pause),
    .dma_req(dma_req), .dma_boundary(dma_boundary), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_size(dma_size), .dma_write(dma_write),
    .dma_gnt(dma_gnt), .dma_active(dma_active),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_size(bus_size),
    .bus_write(bus_write), .bus_pause(bus_pause), .owner_cycles(owner_cycles)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] req;
    logic       pre;
    logic       bp;
    logic [3:0] gnt;
    logic       pause;
    int         src;
    logic       wr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic pre, input logic bp, input logic [3:0] bnd);
    @(negedge clock);
    dma_req = req; cpu_preemptable = pre; bus_pause = bp; dma_boundary = bnd;
    #1;
  endtask

  function automatic vec_t mk(logic [3:0] req, logic pre, logic bp, logic [3:0] gnt,
                              logic pause, int src, logic wr);
    vec_t v;
    v.req = req; v.pre = pre; v.bp = bp; v.gnt = gnt; v.pause = pause; v.src = src; v.wr = wr;
    return v;
  endfunction

  function automatic logic [31:0] src_addr(int src);
    return (src < 0) ? cpu_addr : dma_addr[src];
  endfunction

  function automatic int winner(logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  // Reference model: who owns the bus and which handoff (if any) is in progress.
  int          m_own, m_hand;
  int unsigned m_cnt;

  task automatic model_check();
    int src;
    logic busy;
    logic [3:0] egnt;
    busy = (m_hand != NONE);
    src  = busy ? m_hand : m_own;
    egnt = (!busy && m_own >= 0) ? 4'(1 << m_own) : 4'b0;
    chk("rnd_gnt", dma_gnt, egnt);
    chk("rnd_active", dma_active, egnt != 0);
    chk("rnd_pause", cpu_pause, bus_pause | busy | (m_own >= 0));
    chk("rnd_addr", bus_addr, src_addr(src));
    chk("rnd_wdata_size_wr", {bus_wdata, bus_size, bus_write},
        (src < 0) ? {cpu_wdata, cpu_size, busy ? 1'b0 : cpu_write}
                  : {dma_wdata[src], dma_size[src], busy ? 1'b0 : dma_write[src]});
    chk("rnd_owner_cycles", owner_cycles, 64'(m_cnt));
  endtask

  task automatic model_step();
    int w;
    logic moved;
    if (reset) begin
      m_own = CPU; m_hand = NONE; m_cnt = 0;
    end else if (m_hand != NONE) begin
      m_own = m_hand; m_hand = NONE; m_cnt = 0;
    end else begin
      w = winner(dma_req);
      moved = 1'b0;
      if (m_own == CPU) begin
        if (w >= 0 && cpu_preemptable && !bus_pause) begin m_hand = w; moved = 1'b1; end
      end else if (!dma_req[m_own] && !bus_pause) begin
        m_hand = w; moved = 1'b1;
      end else if (w >= 0 && w < m_own && dma_boundary[m_own] && !bus_pause) begin
        m_hand = w; moved = 1'b1;
      end
      if (moved) m_cnt = 0;
      else if (m_cnt < 65535) m_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1;
    cpu_addr = 32'hC000_0000; cpu_wdata = 32'h1111_2222; cpu_size = 2'd2; cpu_write = 1'b1;
    cpu_preemptable = 1'b1; bus_pause = 1'b0;
    dma_req = '0; dma_boundary = '0; dma_write = 4'hF;
    for (int i = 0; i < 4; i++) begin
      dma_addr[i]  = 32'hD000_0000 + 32'(i);
      dma_wdata[i] = 32'hA000_0000 + 32'(i);
      dma_size[i]  = 2'(i);
    end

    // Reset state
    repeat (3) drive(4'b0000, 1'b1, 1'b0, 4'b0000);
    chk("reset_gnt", dma_gnt, 4'b0);
    chk("reset_active", dma_active, 1'b0);
    chk("reset_pause", cpu_pause, 1'b0);
    chk("reset_cycles", owner_cycles, 16'h0);
    chk("reset_addr", bus_addr, 32'hC000_0000);
    reset = 1'b0;

    // Cycle-by-cycle vectors: initial grant, gating, late drop, drop-with-higher
    for (int i = 0; i < 5; i++) tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 1, 2,   0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(4'b0100, 1, 0, 4'b0100, 1, 2, 1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0100, 1, 2,   1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, CPU, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0000, 1, CPU, 1));
    tbl.push_back(mk(4'b0010, 1, 1, 4'b0000, 1, CPU, 1));
    tbl.push_back(mk(4'b0010, 0, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0010, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0010, 1, 0, 4'b0000, 1, 1,   0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0010, 1, 1,   1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, CPU, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b1000, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, 3,   0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b1000, 1, 3,   1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, CPU, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 0, CPU, 1));
    tbl.push_back(mk(4'b0100, 1, 0, 4'b0000, 1, 2,   0));
    tbl.push_back(mk(4'b0001, 1, 0, 4'b0100, 1, 2,   1));
    tbl.push_back(mk(4'b0001, 1, 0, 4'b0000, 1, 0,   0));
    tbl.push_back(mk(4'b0001, 1, 0, 4'b0001, 1, 0,   1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0001, 1, 0,   1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, CPU, 0));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, CPU, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].pre, tbl[i].bp, 4'b0000);
      chk($sformatf("tbl%0d_gnt", i), dma_gnt, tbl[i].gnt);
      chk($sformatf("tbl%0d_active", i), dma_active, tbl[i].gnt != 0);
      chk($sformatf("tbl%0d_pause", i), cpu_pause, tbl[i].pause);
      chk($sformatf("tbl%0d_write", i), bus_write, tbl[i].wr);
      chk($sformatf("tbl%0d_addr", i), bus_addr, src_addr(tbl[i].src));
    end

    // Boundary preemption DMA3 -> DMA0 -> DMA3 without releasing the CPU
    drive(4'b1000, 1, 0, 4'b0000); chk("bp_decide_gnt", dma_gnt, 4'b0000);
    drive(4'b1000, 0, 0, 4'b0000); chk("bp_hd_addr", bus_addr, dma_addr[3]);
    drive(4'b1000, 0, 0, 4'b0000); chk("bp_own3", dma_gnt, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1001, 0, 0, 4'b0000); chk("bp_no_bnd", dma_gnt, 4'b1000);
    end
    drive(4'b1001, 0, 0, 4'b1000); chk("bp_bnd_cycle", dma_gnt, 4'b1000);
    drive(4'b1001, 0, 0, 4'b0000);
    chk("bp_hd_gnt", dma_gnt, 4'b0000);
    chk("bp_hd_pause", cpu_pause, 1'b1);
    chk("bp_hd_write", bus_write, 1'b0);
    chk("bp_hd0_addr", bus_addr, dma_addr[0]);
    drive(4'b1001, 0, 0, 4'b0000); chk("bp_own0", dma_gnt, 4'b0001);
    drive(4'b1000, 0, 0, 4'b0000); chk("bp_own0_drop", dma_gnt, 4'b0001);
    drive(4'b1000, 0, 0, 4'b0000);
    chk("bp_regrant_hd_pause", cpu_pause, 1'b1);
    chk("bp_regrant_hd_addr", bus_addr, dma_addr[3]);
    drive(4'b1000, 0, 0, 4'b0000); chk("bp_regrant3", dma_gnt, 4'b1000);
    drive(4'b0000, 1, 0, 4'b0000); chk("bp_last3", dma_gnt, 4'b1000);
    drive(4'b0000, 1, 0, 4'b0000); chk("bp_hc_pause", cpu_pause, 1'b1);
    drive(4'b0000, 1, 0, 4'b0000); chk("bp_cpu_pause", cpu_pause, 1'b0);

    // No preemption of DMA2 without its own boundary (other channels' pulses ignored)
    drive(4'b0100, 1, 0, 4'b0000);
    drive(4'b0100, 1, 0, 4'b0000);
    for (int i = 0; i < 50; i++) begin
      drive(4'b0101, 1, 0, (i % 3 == 0) ? 4'b0001 : 4'b0000);
      chk("np_hold2", dma_gnt, 4'b0100);
    end

    // Owner drop with DMA0 pending goes straight to DMA0, then saturation
    drive(4'b0001, 1, 0, 4'b0000); chk("sat_last2", dma_gnt, 4'b0100);
    drive(4'b0001, 1, 0, 4'b0000); chk("sat_hd_addr", bus_addr, dma_addr[0]);
    drive(4'b0001, 1, 0, 4'b0000);
    chk("sat_own0", dma_gnt, 4'b0001);
    chk("sat_cnt0", owner_cycles, 16'd0);
    for (int k = 1; k <= 10; k++) begin
      drive(4'b0001, 1, 0, 4'b0000);
      chk("sat_count", owner_cycles, 64'(k));
    end
    for (int k = 0; k < 70000; k++) drive(4'b0001, 1, 0, 4'b0000);
    chk("sat_full", owner_cycles, 16'hFFFF);
    drive(4'b0001, 1, 0, 4'b0000);
    chk("sat_stay", owner_cycles, 16'hFFFF);
    chk("sat_gnt", dma_gnt, 4'b0001);

    // Reset mid-transfer
    @(negedge clock); reset = 1'b1; bus_pause = 1'b0;
    @(posedge clock); #1;
    chk("rst_gnt", dma_gnt, 4'b0000);
    chk("rst_active", dma_active, 1'b0);
    chk("rst_pause_lo", cpu_pause, 1'b0);
    chk("rst_cycles", owner_cycles, 16'h0);
    bus_pause = 1'b1; #1;
    chk("rst_pause_hi", cpu_pause, 1'b1);

    // Random stimulus against the reference model
    m_own = CPU; m_hand = NONE; m_cnt = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) dma_req[i] = ~dma_req[i];
        dma_addr[i]  = $urandom;
        dma_wdata[i] = $urandom;
        dma_size[i]  = 2'($urandom);
      end
      dma_write       = 4'($urandom);
      dma_boundary    = 4'($urandom) & 4'($urandom);
      bus_pause       = ($urandom_range(0, 3) == 0);
      cpu_preemptable = ($urandom_range(0, 3) != 0);
      cpu_addr        = $urandom;
      cpu_wdata       = $urandom;
      cpu_size        = 2'($urandom);
      cpu_write       = 1'($urandom);
      #1;
      model_check();
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
